// File: rtl/crg_stream.sv
// crg_stream: flow-controlled correlated-randomness (Beaver triple) generator.
// Jobs arrive on a valid/ready command port; each counter value in the job
// yields one triple share, delivered through a credit-protected output FIFO.

package crg_pkg;
   typedef logic [63:0] prng_t;
   typedef logic [63:0] key_t;
   typedef logic [15:0] cr_cnt_t;
   typedef logic        mode_t;
   typedef logic [1:0]  width_t;    // lane width = 8 << width_t

   localparam mode_t MODE_ARITH = 1'b0;
   localparam mode_t MODE_BOOL  = 1'b1;

   typedef struct packed {
      logic    valid;
      logic    epoch;
      logic    last;
      cr_cnt_t cnt;
      prng_t   a;
      prng_t   b;
      prng_t   c;
   } sr_t;

   typedef struct packed {
      logic    last;
      cr_cnt_t cnt;
      prng_t   a;
      prng_t   b;
      prng_t   c;
   } fifo_t;
endpackage

module crg_stream
   import crg_pkg::*;
#(
   parameter int unsigned LATENCY    = 27,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic    clk_i,
   input  logic    rst_n_i,
   input  logic    cmd_valid_i,
   output logic    cmd_ready_o,
   input  logic    cmd_party_i,
   input  key_t    cmd_key_i,
   input  mode_t   cmd_mode_i,
   input  width_t  cmd_width_i,
   input  cr_cnt_t cmd_start_i,
   input  cr_cnt_t cmd_end_i,
   input  logic    abort_i,
   output logic    out_valid_o,
   input  logic    out_ready_i,
   output prng_t   out_a_o,
   output prng_t   out_b_o,
   output prng_t   out_c_o,
   output cr_cnt_t out_cnt_o,
   output logic    out_last_o,
   output logic    busy_o,
   output logic    err_o
);

   if (FIFO_DEPTH < LATENCY + 2) begin : g_bad_depth
      $error("crg_stream: FIFO_DEPTH must be at least LATENCY+2");
   end

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   // Keyed counter-mode generator (splitmix64 finaliser over key^{prefix,cnt}).
   function automatic prng_t prng_mix(input logic [2:0] prefix, input key_t key, input cr_cnt_t cnt);
      prng_t z;
      z = (key ^ {prefix, 45'd0, cnt}) + 64'h9E3779B97F4A7C15;
      z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
      z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
      return z ^ (z >> 31);
   endfunction

   // Lane-wise sub/mul mod 2^width (arith) or xor/and (bool).
   function automatic prng_t lane_op(input prng_t x, input prng_t y, input mode_t mode,
                                     input width_t width, input logic mul);
      prng_t r;
      r = '0;
      if (mode == MODE_BOOL) begin
         r = mul ? (x & y) : (x ^ y);
      end else begin
         case (width)
            2'd0: for (int unsigned i = 0; i < 8; i++)
                     r[i*8 +: 8] = mul ? x[i*8 +: 8] * y[i*8 +: 8] : x[i*8 +: 8] - y[i*8 +: 8];
            2'd1: for (int unsigned i = 0; i < 4; i++)
                     r[i*16 +: 16] = mul ? x[i*16 +: 16] * y[i*16 +: 16] : x[i*16 +: 16] - y[i*16 +: 16];
            2'd2: for (int unsigned i = 0; i < 2; i++)
                     r[i*32 +: 32] = mul ? x[i*32 +: 32] * y[i*32 +: 32] : x[i*32 +: 32] - y[i*32 +: 32];
            default: r = mul ? x * y : x - y;
         endcase
      end
      return r;
   endfunction

   logic [1:0]    state;
   logic          j_party;
   key_t          j_key;
   mode_t         j_mode;
   width_t        j_width;
   cr_cnt_t       j_end;
   cr_cnt_t       iss_cnt;
   logic          epoch;
   logic          err_q;
   logic [CW-1:0] inflight;
   logic [CW-1:0] fcount;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW:0]   credit_sum;
   sr_t           sr [LATENCY];
   sr_t           sr_in;
   fifo_t         mem [FIFO_DEPTH];
   fifo_t         head;
   prng_t         p0, p1, p2, p3, p4;
   logic          accept, issue, issue_last, exit_v, wr, rd;

   assign cmd_ready_o = (state == S_IDLE);
   assign accept      = cmd_valid_i & cmd_ready_o & ~abort_i;
   assign credit_sum  = {1'b0, inflight} + {1'b0, fcount};
   assign issue       = (state == S_ISSUE) & (credit_sum < DEPTH_C) & ~abort_i;
   assign issue_last  = issue & (iss_cnt == j_end);
   assign exit_v      = sr[LATENCY-1].valid;
   // Results from an aborted epoch still retire credits but never reach the FIFO.
   assign wr          = exit_v & (sr[LATENCY-1].epoch == epoch) & ~abort_i;
   assign out_valid_o = (fcount != '0);
   assign rd          = out_valid_o & out_ready_i & ~abort_i;
   assign head        = mem[rd_ptr];
   assign out_a_o     = out_valid_o ? head.a    : '0;
   assign out_b_o     = out_valid_o ? head.b    : '0;
   assign out_c_o     = out_valid_o ? head.c    : '0;
   assign out_cnt_o   = out_valid_o ? head.cnt  : '0;
   assign out_last_o  = out_valid_o ? head.last : 1'b0;
   assign busy_o      = (state != S_IDLE) | (inflight != '0) | (fcount != '0);
   assign err_o       = err_q;

   // Triple share for the counter being issued this cycle.
   always_comb begin
      p0 = prng_mix(3'd0, j_key, iss_cnt);
      p1 = prng_mix(3'd1, j_key, iss_cnt);
      p2 = prng_mix(3'd2, j_key, iss_cnt);
      p3 = prng_mix(3'd3, j_key, iss_cnt);
      p4 = prng_mix(3'd4, j_key, iss_cnt);
      sr_in       = '0;
      sr_in.valid = issue;
      sr_in.epoch = epoch;
      sr_in.last  = issue_last;
      sr_in.cnt   = iss_cnt;
      if (j_party) begin
         sr_in.a = lane_op(p1, p0, j_mode, j_width, 1'b0);
         sr_in.b = lane_op(p2, p3, j_mode, j_width, 1'b0);
         sr_in.c = lane_op(lane_op(p1, p2, j_mode, j_width, 1'b1), p4, j_mode, j_width, 1'b0);
      end else begin
         sr_in.a = p0;
         sr_in.b = p3;
         sr_in.c = p4;
      end
   end

   // Job control FSM, job latches, issue counter, epoch and error pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= S_IDLE;
         j_party <= 1'b0;
         j_key   <= '0;
         j_mode  <= MODE_ARITH;
         j_width <= '0;
         j_end   <= '0;
         iss_cnt <= '0;
         epoch   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= accept & (cmd_end_i < cmd_start_i);
         if (abort_i) begin
            state <= S_IDLE;
            epoch <= ~epoch;
         end else begin
            case (state)
               S_IDLE: if (accept) begin
                  j_party <= cmd_party_i;
                  j_key   <= cmd_key_i;
                  j_mode  <= cmd_mode_i;
                  j_width <= cmd_width_i;
                  j_end   <= cmd_end_i;
                  iss_cnt <= cmd_start_i;
                  if (cmd_end_i >= cmd_start_i) state <= S_ISSUE;
               end
               S_ISSUE: if (issue) begin
                  if (issue_last) state <= S_DRAIN;
                  else            iss_cnt <= iss_cnt + 16'd1;
               end
               S_DRAIN: if (wr && sr[LATENCY-1].last) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Fixed-latency side pipeline carrying results with their tags.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < LATENCY; i++) sr[i] <= '0;
      end else begin
         sr[0] <= sr_in;
         for (int unsigned i = 1; i < LATENCY; i++) sr[i] <= sr[i-1];
      end
   end

   // Credit tracking and FIFO pointers; abort empties the FIFO but not inflight.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         inflight <= '0;
         fcount   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         inflight <= inflight + CW'(issue) - CW'(exit_v);
         if (abort_i) begin
            fcount <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            fcount <= fcount + CW'(wr) - CW'(rd);
            if (wr) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            if (rd) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
         end
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk_i) begin
      if (wr) mem[wr_ptr] <= '{last: sr[LATENCY-1].last, cnt: sr[LATENCY-1].cnt,
                               a: sr[LATENCY-1].a, b: sr[LATENCY-1].b, c: sr[LATENCY-1].c};
   end

endmodule

// File: tb/tb_crg_stream.sv
// Self-checking bench for crg_stream: expected triples are generated per job
// from the arithmetic definition of the shares and consumed in order.
module tb_crg_stream;
   import crg_pkg::*;

   localparam int unsigned LAT   = 27;
   localparam int unsigned DEPTH = 32;

   logic    clk, rst_n;
   logic    cmd_valid, cmd_ready, cmd_party;
   key_t    cmd_key;
   mode_t   cmd_mode;
   width_t  cmd_width;
   cr_cnt_t cmd_start, cmd_end;
   logic    abort, out_valid, out_ready, out_last, busy, err;
   prng_t   out_a, out_b, out_c;
   cr_cnt_t out_cnt;

   crg_stream #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_party_i(cmd_party), .cmd_key_i(cmd_key), .cmd_mode_i(cmd_mode),
      .cmd_width_i(cmd_width), .cmd_start_i(cmd_start), .cmd_end_i(cmd_end),
      .abort_i(abort), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_a_o(out_a), .out_b_o(out_b), .out_c_o(out_c), .out_cnt_o(out_cnt),
      .out_last_o(out_last), .busy_o(busy), .err_o(err)
   );

   typedef struct {
      prng_t       a, b, c;
      cr_cnt_t     cnt;
      logic        last;
      logic        timed;
      int unsigned due;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          vectors = 0;
   int          miscompares = 0;
   int unsigned cyc = 0;
   int          rdy_mode = 2;   // 0: ready held 1, 1: random, 2: held 0
   logic        hold_pending = 0, abort_prev = 0;
   prng_t       prev_a, prev_b, prev_c;
   cr_cnt_t     prev_cnt;

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #2;
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference generator: splitmix64 of key ^ (prefix<<61) ^ counter.
   function automatic prng_t m_prng(input int prefix, input key_t key, input int unsigned n);
      prng_t z;
      z = key ^ (64'(prefix) << 61) ^ 64'(n & 32'hFFFF);
      z = z + 64'h9E3779B97F4A7C15;
      z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
      z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
      return z ^ (z >> 31);
   endfunction

   function automatic prng_t m_op(input prng_t x, input prng_t y, input logic boolean,
                                  input int w, input logic mul);
      prng_t mask, r, lx, ly, v;
      if (boolean) return mul ? (x & y) : (x ^ y);
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      r = '0;
      for (int i = 0; i < 64 / w; i++) begin
         lx = (x >> (i * w)) & mask;
         ly = (y >> (i * w)) & mask;
         v  = mul ? lx * ly : lx - ly;
         r  = r | ((v & mask) << (i * w));
      end
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_job(input logic party, input logic mode, input logic [1:0] width,
                           input int unsigned start, input int unsigned stop, input logic timed);
      int          k;
      int unsigned t;
      key_t        key;
      prng_t       p [5];
      exp_t        x;
      int          w;
      k = 0;
      while (!cmd_ready && k < 5000) begin
         tick(1);
         k++;
      end
      check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      key = {$urandom, $urandom};
      cmd_party = party; cmd_key = key; cmd_mode = mode; cmd_width = width;
      cmd_start = cr_cnt_t'(start); cmd_end = cr_cnt_t'(stop);
      cmd_valid = 1;
      t = cyc;
      w = 8 << width;
      if (stop >= start) begin
         for (int unsigned n = start; n <= stop; n++) begin
            for (int j = 0; j < 5; j++) p[j] = m_prng(j, key, n);
            if (party) begin
               x.a = m_op(p[1], p[0], mode, w, 0);
               x.b = m_op(p[2], p[3], mode, w, 0);
               x.c = m_op(m_op(p[1], p[2], mode, w, 1), p[4], mode, w, 0);
            end else begin
               x.a = p[0]; x.b = p[3]; x.c = p[4];
            end
            x.cnt   = cr_cnt_t'(n);
            x.last  = (n == stop);
            x.timed = timed;
            x.due   = t + 2 + LAT + (n - start);
            exp_q.push_back(x);
         end
      end
      tick(1);
      cmd_valid = 0;
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while ((busy || !cmd_ready) && k < bound) begin
         tick(1);
         k++;
      end
      check("idle_wait", 64'(busy), 64'd0);
      check("all_delivered", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_abort();
      rdy_mode = 2;
      tick(1);
      abort = 1;
      exp_q.delete();
      tick(1);
      abort = 0;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_a"}, out_a, 64'd0);
      check({tag, "_out_b"}, out_b, 64'd0);
      check({tag, "_out_c"}, out_c, 64'd0);
      check({tag, "_out_cnt"}, 64'(out_cnt), 64'd0);
      check({tag, "_out_last"}, 64'(out_last), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
   endtask

   // Output monitor: in-order scoreboard, exact timing where requested, hold stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pending = 0;
         abort_prev   = 0;
      end else begin
         if (hold_pending && !abort_prev) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_a", out_a, prev_a);
            check("hold_b", out_b, prev_b);
            check("hold_c", out_c, prev_c);
            check("hold_cnt", 64'(out_cnt), 64'(prev_cnt));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_triple: got cnt %0d expected no output (cycle %0d)", out_cnt, cyc);
            end else begin
               e = exp_q.pop_front();
               check("triple_a", out_a, e.a);
               check("triple_b", out_b, e.b);
               check("triple_c", out_c, e.c);
               check("triple_cnt", 64'(out_cnt), 64'(e.cnt));
               check("triple_last", 64'(out_last), 64'(e.last));
               if (e.timed) check("triple_cycle", 64'(cyc), 64'(e.due));
            end
         end
         hold_pending = out_valid && !out_ready;
         prev_a = out_a; prev_b = out_b; prev_c = out_c; prev_cnt = out_cnt;
         abort_prev = abort;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 0; cmd_valid = 0; cmd_party = 0; cmd_key = '0; cmd_mode = 0; cmd_width = 0;
      cmd_start = '0; cmd_end = '0; abort = 0; out_ready = 0;

      // Pin the reference model to hand-computed values.
      check("model_prng0", m_prng(0, 64'd0, 0), 64'hE220A8397B1DCDAF);
      check("model_sub8", m_op(64'h0102030405060708, 64'h0101010101010101, 0, 8, 0), 64'h0001020304050607);
      check("model_sub8_wrap", m_op(64'h0, 64'h1, 0, 8, 0), 64'h00000000000000FF);
      check("model_mul16", m_op(64'h0000000001000003, 64'h0000000001000005, 0, 16, 1), 64'h000000000000000F);
      check("model_mul64", m_op(64'hFFFFFFFFFFFFFFFF, 64'h2, 0, 64, 1), 64'hFFFFFFFFFFFFFFFE);
      check("model_and", m_op(64'hF0F0, 64'hFF00, 1, 8, 1), 64'hF000);
      check("model_xor", m_op(64'hF0F0, 64'hFF00, 1, 8, 0), 64'h0FF0);

      tick(3);
      check_reset_outputs("reset");
      rst_n = 1;
      tick(2);

      // Party 0 arith 0..3, exact timing.
      rdy_mode = 0;
      tick(1);
      send_job(0, MODE_ARITH, 2'd0, 0, 3, 1);
      wait_idle(200);

      // Party 1, 8-bit lanes, bool then arith, exact timing.
      send_job(1, MODE_BOOL, 2'd0, 100, 163, 1);
      wait_idle(300);
      send_job(1, MODE_ARITH, 2'd0, 100, 163, 1);
      wait_idle(300);

      // Random back-to-back jobs under random back-pressure.
      rdy_mode = 1;
      for (int j = 0; j < 6; j++)
         send_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 60000), 0, 0);
      for (int j = 0; j < 4; j++) begin
         int unsigned s;
         s = $urandom_range(0, 60000);
         send_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  s, s + $urandom_range(1, 40), 0);
      end
      wait_idle(3000);

      // Long job with 200 stalled cycles at the start.
      rdy_mode = 2;
      send_job(0, MODE_ARITH, 2'd1, 0, 999, 0);
      tick(200);
      rdy_mode = 0;
      wait_idle(3000);

      // Abort mid-issue, then a short job; no stale triples may appear.
      rdy_mode = 2;
      send_job(1, MODE_ARITH, 2'd2, 0, 999, 0);
      tick(12);
      do_abort();
      rdy_mode = 0;
      send_job(0, MODE_BOOL, 2'd3, 500, 501, 0);
      wait_idle(300);

      // Abort colliding with a command in IDLE: command is dropped.
      cmd_start = 16'd7; cmd_end = 16'd9; cmd_valid = 1; abort = 1;
      tick(1);
      cmd_valid = 0; abort = 0;
      check("abort_cmd_ready_idle", 64'(cmd_ready), 64'd1);
      tick(LAT + 8);
      wait_idle(100);

      // Rejected job: end < start.
      send_job(0, MODE_ARITH, 2'd0, 5, 4, 0);
      check("err_pulse", 64'(err), 64'd1);
      check("err_cmd_ready", 64'(cmd_ready), 64'd1);
      tick(1);
      check("err_single", 64'(err), 64'd0);
      tick(LAT + 5);
      check("err_no_busy", 64'(busy), 64'd0);

      // Single triple at counter max.
      send_job(1, MODE_BOOL, 2'd0, 65535, 65535, 1);
      wait_idle(200);

      // Async reset while draining.
      send_job(0, MODE_ARITH, 2'd0, 0, 40, 0);
      tick(55);
      #3;
      rst_n = 0;
      #1;
      check_reset_outputs("drain_reset");
      exp_q.delete();
      tick(2);
      rst_n = 1;
      tick(1);
      send_job(1, MODE_ARITH, 2'd1, 10, 20, 1);
      wait_idle(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
